// File: rtl/audio_pwm_dac.sv
// PWM audio DAC: a free-running period counter, a double-buffered sample path and a
// per-period gain ramp that fades the output in and out when the enable level changes.
module audio_pwm_dac #(
    parameter int WIDTH     = 9,
    parameter int RAMP_STEP = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_sample,
    input  logic             i_sample_stb,
    input  logic             i_enable,
    output logic             o_pwm,
    output logic             o_period_stb,
    output logic             o_active,
    output logic [8:0]       o_gain
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam int               PROD_W  = WIDTH + 9;
    localparam logic [9:0]       STEP    = 10'(RAMP_STEP);
    localparam logic [9:0]       UNITY   = 10'd256;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RUN,
        RAMP_DOWN
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  cnt_reg;
    logic [WIDTH-1:0]  pending_reg;
    logic [WIDTH-1:0]  duty_reg, duty_next;
    logic [8:0]        gain_reg, gain_next;
    logic              pwm_reg;
    logic              period_stb_reg;
    logic              active_reg;

    logic              boundary;
    logic [WIDTH-1:0]  src;
    logic [PROD_W-1:0] product;
    logic [9:0]        gain_up;
    logic [8:0]        gain_up_sat;
    logic [8:0]        gain_down_sat;

    // A sample strobed on the boundary cycle itself bypasses the pending buffer.
    always_comb begin
        boundary  = (cnt_reg == CNT_MAX);
        src       = i_sample_stb ? i_sample : pending_reg;
        product   = PROD_W'(src) * PROD_W'(gain_reg);
        duty_next = WIDTH'(product >> 8);
    end

    always_comb begin
        gain_up       = {1'b0, gain_reg} + STEP;
        gain_up_sat   = (gain_up >= UNITY) ? 9'd256 : gain_up[8:0];
        gain_down_sat = ({1'b0, gain_reg} <= STEP) ? 9'd0 : 9'(({1'b0, gain_reg} - STEP));
    end

    // Leaving IDLE or RUN applies a step on the same edge; reversing mid-ramp holds gain one period.
    always_comb begin
        state_next = state_reg;
        gain_next  = gain_reg;
        if (boundary) begin
            case (state_reg)
                IDLE: begin
                    gain_next = 9'd0;
                    if (i_enable) begin
                        gain_next  = gain_up_sat;
                        state_next = (gain_up_sat == 9'd256) ? RUN : RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (!i_enable) begin
                        state_next = RAMP_DOWN;
                    end else begin
                        gain_next  = gain_up_sat;
                        state_next = (gain_up_sat == 9'd256) ? RUN : RAMP_UP;
                    end
                end
                RUN: begin
                    gain_next = 9'd256;
                    if (!i_enable) begin
                        gain_next  = gain_down_sat;
                        state_next = (gain_down_sat == 9'd0) ? IDLE : RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (i_enable) begin
                        state_next = RAMP_UP;
                    end else begin
                        gain_next  = gain_down_sat;
                        state_next = (gain_down_sat == 9'd0) ? IDLE : RAMP_DOWN;
                    end
                end
                default: begin
                    state_next = IDLE;
                    gain_next  = 9'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            gain_reg       <= 9'd0;
            active_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            gain_reg       <= gain_next;
            active_reg     <= (state_next != IDLE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_reg        <= '0;
            pending_reg    <= '0;
            duty_reg       <= '0;
            pwm_reg        <= 1'b0;
            period_stb_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_reg + 1'b1;
            if (i_sample_stb) begin
                pending_reg <= i_sample;
            end
            if (boundary) begin
                duty_reg <= duty_next;
            end
            pwm_reg        <= (cnt_reg < duty_reg);
            period_stb_reg <= (cnt_reg == '0);
        end
    end

    assign o_pwm        = pwm_reg;
    assign o_period_stb = period_stb_reg;
    assign o_active     = active_reg;
    assign o_gain       = gain_reg;

endmodule
